// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_gen_pipe_if : producer/consumer bundle for imm_gen_pipe            |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
interface imm_gen_pipe_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [2:0]      in_src;
    logic [TAGW-1:0] in_tag;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [TAGW-1:0] out_tag;
    logic            out_err;

    modport master (
        output in_valid, in_inst, in_src, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_inst, in_src, in_tag, flush, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_gen_pipe : immediate extraction into a 2-entry skid buffer         |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int TAGW = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    imm_gen_pipe_if.slave    bus
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_accept;
    logic            w_pop;
    logic            w_load_main;
    logic            w_load_skid;
    logic            w_skid_to_main;

    logic [XLEN-1:0] w_imm;
    logic            w_err;
    logic            w_sign;

    logic [XLEN-1:0] r_main_imm;
    logic [TAGW-1:0] r_main_tag;
    logic            r_main_err;
    logic [XLEN-1:0] r_skid_imm;
    logic [TAGW-1:0] r_skid_tag;
    logic            r_skid_err;

    // Opcode bits play no part in immediate selection.
    logic            w_unused;
    assign w_unused = &{1'b0, bus.in_inst[6:0]};

    assign w_sign = bus.in_inst[31];

    always_comb begin
        w_imm = '0;
        w_err = 1'b0;
        case (bus.in_src)
            3'b000: w_imm = {{(XLEN-11){w_sign}}, bus.in_inst[30:20]};
            3'b001: w_imm = {{(XLEN-11){w_sign}}, bus.in_inst[30:25], bus.in_inst[11:7]};
            3'b010: w_imm = {{(XLEN-12){w_sign}}, bus.in_inst[7], bus.in_inst[30:25],
                             bus.in_inst[11:8], 1'b0};
            3'b011: w_imm = {{(XLEN-20){w_sign}}, bus.in_inst[19:12], bus.in_inst[20],
                             bus.in_inst[30:21], 1'b0};
            3'b100: w_imm = {{(XLEN-31){w_sign}}, bus.in_inst[30:12], 12'b0};
            3'b101: w_imm = {{(XLEN-5){1'b0}}, bus.in_inst[19:15]};
            3'b110: w_imm = (XLEN == 64) ? {{(XLEN-6){1'b0}}, bus.in_inst[25:20]}
                                         : {{(XLEN-5){1'b0}}, bus.in_inst[24:20]};
            default: begin
                w_imm = '0;
                w_err = 1'b1;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_accept && !w_pop)      w_state_nxt = S_TWO;
                    else if (!w_accept && w_pop) w_state_nxt = S_EMPTY;
                end
                S_TWO:   if (w_pop) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Output / control decode from registered state only.
    always_comb begin
        w_in_ready     = (r_state != S_TWO);
        w_out_valid    = (r_state != S_EMPTY);
        w_accept       = bus.in_valid & w_in_ready & ~bus.flush;
        w_pop          = w_out_valid & bus.out_ready;
        w_load_main    = w_accept & ((r_state == S_EMPTY) | ((r_state == S_ONE) & w_pop));
        w_load_skid    = w_accept & (r_state == S_ONE) & ~w_pop;
        w_skid_to_main = w_pop & (r_state == S_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_imm <= '0;
            r_main_tag <= '0;
            r_main_err <= 1'b0;
            r_skid_imm <= '0;
            r_skid_tag <= '0;
            r_skid_err <= 1'b0;
        end else begin
            if (w_load_main) begin
                r_main_imm <= w_imm;
                r_main_tag <= bus.in_tag;
                r_main_err <= w_err;
            end else if (w_skid_to_main) begin
                r_main_imm <= r_skid_imm;
                r_main_tag <= r_skid_tag;
                r_main_err <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_imm;
                r_skid_tag <= bus.in_tag;
                r_skid_err <= w_err;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_imm   = r_main_imm;
    assign bus.out_tag   = r_main_tag;
    assign bus.out_err   = r_main_err;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imm_gen_pipe : directed bench driving XLEN=32 and XLEN=64 copies    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [2:0]  in_src;
    logic [7:0]  in_tag;
    logic        flush;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAGW(8)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAGW(8)) bus64 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.in_inst   = in_inst;
    assign bus32.in_src    = in_src;
    assign bus32.in_tag    = in_tag;
    assign bus32.flush     = flush;
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.in_inst   = in_inst;
    assign bus64.in_src    = in_src;
    assign bus64.in_tag    = in_tag;
    assign bus64.flush     = flush;
    assign bus64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAGW(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    imm_gen_pipe #(.XLEN(64), .TAGW(8)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

    // Directed vectors: inst, src, expected XLEN=32, expected XLEN=64, expected err
    logic [31:0] v_inst [9] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h0080006F,
                                32'h800000B7, 32'h0007D073, 32'h03F01093, 32'hFFFFFFFF,
                                32'hFFF00093};
    logic [2:0]  v_src  [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [31:0] v_e32  [9] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000008,
                                32'h80000000, 32'h0000000F, 32'h0000001F, 32'h00000000,
                                32'hFFFFFFFF};
    logic [63:0] v_e64  [9] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                                64'h8, 64'hFFFFFFFF80000000, 64'hF, 64'h3F, 64'h0,
                                64'hFFFFFFFFFFFFFFFF};
    logic        v_err  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int    next_tag;
        int    got[$];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_src    = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus32.in_ready),  64'd1);
        check("rst_imm32",     64'(bus32.out_imm),   64'd0);
        check("rst_imm64",     bus64.out_imm,        64'd0);
        check("rst_tag",       64'(bus32.out_tag),   64'd0);
        check("rst_err",       64'(bus32.out_err),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Format sweep streamed back-to-back with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_inst  = v_inst[i];
            in_src   = v_src[i];
            in_tag   = 8'(i + 1);
            tick();
            check($sformatf("sweep_valid[%0d]", i), 64'(bus32.out_valid), 64'd1);
            check($sformatf("sweep_imm32[%0d]", i), 64'(bus32.out_imm),   64'(v_e32[i]));
            check($sformatf("sweep_imm64[%0d]", i), bus64.out_imm,        v_e64[i]);
            check($sformatf("sweep_err[%0d]", i),   64'(bus32.out_err),   64'(v_err[i]));
            check($sformatf("sweep_tag[%0d]", i),   64'(bus32.out_tag),   64'(i + 1));
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(bus32.out_valid), 64'd0);

        // Back-pressure: two entries fill the buffer, third stalls
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00100093;
        in_src    = 3'd0;
        in_tag    = 8'd1;
        tick();
        check("bp_ready_one", 64'(bus32.in_ready), 64'd1);
        check("bp_tag_one",   64'(bus32.out_tag),  64'd1);
        in_tag = 8'd2;
        tick();
        check("bp_ready_two", 64'(bus32.in_ready), 64'd0);
        check("bp_tag_two",   64'(bus32.out_tag),  64'd1);
        in_tag = 8'd3;
        tick();
        check("bp_hold_ready", 64'(bus32.in_ready), 64'd0);
        check("bp_hold_tag",   64'(bus32.out_tag),  64'd1);

        out_ready = 1'b1;
        next_tag  = 3;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            if (bus32.out_valid && out_ready) got.push_back(int'(bus32.out_tag));
            if (in_valid && bus32.in_ready) next_tag++;
            tick();
            in_valid = (next_tag <= 4);
            in_tag   = 8'(next_tag);
        end
        in_valid = 1'b0;
        check("bp_count", 64'(got.size()), 64'd4);
        for (int k = 0; k < got.size(); k++) begin
            check($sformatf("bp_order[%0d]", k), 64'(got[k]), 64'(k + 1));
        end
        tick();
        check("bp_empty", 64'(bus32.out_valid), 64'd0);

        // Flush from ONE: flush-cycle input must not be accepted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 8'd20;
        tick();
        in_tag = 8'd21;
        flush  = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl1_valid", 64'(bus32.out_valid), 64'd0);
        check("fl1_ready", 64'(bus32.in_ready),  64'd1);

        // Flush from TWO
        in_valid = 1'b1;
        in_tag   = 8'd10;
        tick();
        in_tag = 8'd11;
        tick();
        check("fl2_full", 64'(bus32.in_ready), 64'd0);
        in_tag = 8'd12;
        flush  = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl2_valid", 64'(bus32.out_valid), 64'd0);
        check("fl2_ready", 64'(bus32.in_ready),  64'd1);
        out_ready = 1'b1;
        tick();
        check("fl2_nothing", 64'(bus32.out_valid), 64'd0);

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'hFFF00093;
        in_src    = 3'd0;
        in_tag    = 8'd30;
        tick();
        in_tag = 8'd31;
        tick();
        in_valid = 1'b0;
        check("ar_full", 64'(bus32.in_ready), 64'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(bus32.out_valid), 64'd0);
        check("ar_ready", 64'(bus32.in_ready),  64'd1);
        check("ar_imm32", 64'(bus32.out_imm),   64'd0);
        check("ar_imm64", bus64.out_imm,        64'd0);
        check("ar_tag",   64'(bus32.out_tag),   64'd0);
        check("ar_err",   64'(bus32.out_err),   64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("ar_after", 64'(bus32.out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. Accepts an instruction word with its immediate-format select over a valid/ready handshake, extracts and sign/zero-extends the immediate to XLEN bits, and presents it registered with a pass-through tag. A 2-entry skid buffer sustains one result per cycle under back-pressure, and a flush input discards in-flight entries on redirect.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- TAGW, 8: width of the sideband tag (PC index / ROB id) carried with each entry.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  producer presents inst/src/tag.
- in_ready  output  1  block can accept this cycle.
- in_inst  input  32  raw instruction word.
- in_src  input  3  immediate format select.
- in_tag  input  TAGW  sideband, returned unchanged.
- flush  input  1  discard all held and incoming entries.
- out_valid  output  1  out_imm/out_tag/out_err valid.
- out_ready  input  1  consumer takes the output this cycle.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAGW  tag of the presented entry.
- out_err  output  1  the presented entry had an unsupported in_src.

## Operation
- Formats (s = inst[31], sign-extended to XLEN unless noted):
  - 000 I: s, inst[30:20].
  - 001 S: s, inst[30:25], inst[11:7].
  - 010 B: s, inst[7], inst[30:25], inst[11:8], 0.
  - 011 J: s, inst[19:12], inst[20], inst[30:21], 0.
  - 100 U: inst[31:12], 12'b0; for XLEN=64, sign-extended from bit 31.
  - 101 Z (CSR uimm): inst[19:15], zero-extended.
  - 110 SH (shift amount): inst[24:20] zero-extended for XLEN=32; inst[25:20] for XLEN=64.
  - 111: out_imm = 0, out_err = 1. Never produces X.
- Extraction is combinational on input; the result plus tag and error bit is stored in the buffer.
- Buffer: main entry (drives outputs) and skid entry. FSM states:
  - EMPTY: accept -> ONE.
  - ONE: accept & pop -> ONE (new entry into main); accept & !pop -> TWO (new entry into skid); pop & !accept -> EMPTY.
  - TWO: pop -> ONE (skid moves to main); no accept.
- accept = in_valid & in_ready & !flush; pop = out_valid & out_ready.
- in_ready = (state != TWO); this is a pure function of registered state, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Entries leave in acceptance order. Outputs hold stable while out_valid & !out_ready.

## Timing
- Reset (asynchronous, rst_n low): state EMPTY; out_valid 0, in_ready 1, out_imm 0, out_tag 0, out_err 0. Release is synchronous to clk.
- Reset asserted mid-operation drops all entries immediately, with no wait for a clock edge.
- Latency: an entry accepted at edge N is visible with out_valid=1 after edge N, if the buffer was EMPTY or the main entry popped at N.
- Throughput: 1 entry/cycle when out_ready is held 1.
- flush: at the next edge the state goes to EMPTY and out_valid goes to 0. An input presented in the flush cycle is not accepted. A pop in the flush cycle still completes, because the consumer saw valid. in_ready reads 1 in the cycle after the flush.
- Simultaneous accept and pop in TWO cannot occur, because in_ready is 0.
- Data registers are not cleared on pop or flush. Only reset zeroes them.

## Test plan
- Reset/format sweep, XLEN=32: in_inst=0xFFF00093 with src 000 -> out_imm 0xFFFFFFFF. 0xFE000EE3 with src 010 -> 0xFFFFFFFC. 0x800000B7 with src 100 -> 0x80000000. 0x0007D073 with src 101 -> 0x0000000F. Each result appears 1 cycle after accept, with out_err 0.
- XLEN=64: 0x800000B7 with src 100 -> 0xFFFFFFFF80000000. 0x03F01093 with src 110 -> 0x3F.
- Back-pressure: stream 4 entries with tags 1..4 while out_ready=0. After 2 accepts in_ready drops to 0 and out_tag holds 1. Raise out_ready: tags 1, 2, 3, 4 are delivered in order, none are lost, and there are no duplicates.
- Flush: hold 2 entries and assert flush together with in_valid. The next cycle shows out_valid 0 and in_ready 1, and the flush-cycle input is not seen at the output.
- Illegal select: src 111 with any inst -> out_imm 0 and out_err 1. The following legal entry shows out_err 0.
- Async reset: drop rst_n mid-clock with 2 entries held. out_valid goes to 0 and in_ready to 1 before the next edge, and all outputs read 0.
